// File: rtl/mbist_sched_pkg.sv
// Shared definitions for the MBIST scheduler: FSM encodings and
// the memory-index width helper.
package mbist_sched_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ERST = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_CAPT = 3'd3;
  localparam logic [2:0] ST_NEXT = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  // Index width for n memories, never below one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mbist_next_sel.sv
// Find-next-set-bit over the memory mask: lowest set bit when
// first_i is high, else lowest set bit strictly above idx_i.
module mbist_next_sel #(
  parameter int NUM_MEM = 4,
  parameter int SEL_W   = 2
) (
  input  logic [NUM_MEM-1:0] mask_i,
  input  logic [SEL_W-1:0]   idx_i,
  input  logic               first_i,
  output logic [SEL_W-1:0]   nxt_idx_o,
  output logic               none_o
);

  always_comb begin
    nxt_idx_o = '0;
    none_o    = 1'b1;
    for (int i = NUM_MEM - 1; i >= 0; i--) begin
      if (mask_i[i] && (first_i || (i > int'(idx_i)))) begin
        nxt_idx_o = SEL_W'(i);
        none_o    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mbist_sched.sv
// Sequences one shared MBIST engine over NUM_MEM memories in index order.
// Optional per-memory watchdog: define MBIST_TIMEOUT_EN.
module mbist_sched
  import mbist_sched_pkg::*;
#(
  parameter int NUM_MEM   = 4,
  parameter int SEL_W     = sel_w(NUM_MEM),
  parameter int TO_CYCLES = 4096,
  parameter int TO_W      = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NUM_MEM-1:0] mem_mask,
  input  logic               eng_done,
  input  logic               eng_fault,
  output logic               eng_rst,
  output logic               eng_mode,
  output logic [SEL_W-1:0]   eng_sel,
  output logic               busy,
  output logic               done,
  output logic [NUM_MEM-1:0] fail_map,
  output logic [NUM_MEM-1:0] timeout_map
);

  if (TO_W < 1 || TO_CYCLES < 1 ||
      (64'd1 << TO_W) <= 64'(TO_CYCLES)) begin : g_bad_cfg
    $error("mbist_sched: TO_W too narrow for TO_CYCLES");
  end

  logic [2:0]         state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [NUM_MEM-1:0] mask_q, mask_d;
  logic [NUM_MEM-1:0] fail_q, fail_d;
  logic [NUM_MEM-1:0] to_q, to_d;
  logic               acc_q, acc_d;
  logic               mode_q, busy_q, done_q;

  logic               idle_like;
  logic [NUM_MEM-1:0] scan_mask;
  logic [SEL_W-1:0]   nxt_idx;
  logic               nxt_none;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign scan_mask = idle_like ? mem_mask : mask_q;

  mbist_next_sel #(
    .NUM_MEM (NUM_MEM),
    .SEL_W   (SEL_W)
  ) u_next_sel (
    .mask_i    (scan_mask),
    .idx_i     (idx_q),
    .first_i   (idle_like),
    .nxt_idx_o (nxt_idx),
    .none_o    (nxt_none)
  );

`ifdef MBIST_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);
  logic [TO_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    fail_d  = fail_q;
    to_d    = to_q;
    acc_d   = acc_q;
`ifdef MBIST_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mask_d  = mem_mask;
          fail_d  = '0;
          to_d    = '0;
          acc_d   = 1'b0;
          idx_d   = nxt_idx;
          state_d = nxt_none ? ST_DONE : ST_ERST;
        end
      end
      ST_ERST: begin
        acc_d   = 1'b0;
`ifdef MBIST_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = ST_RUN;
      end
      ST_RUN: begin
        acc_d = acc_q | eng_fault;
        if (eng_done) begin
          state_d = ST_CAPT;
`ifdef MBIST_TIMEOUT_EN
        end else if (cnt_q == TO_LAST) begin
          fail_d[idx_q] = 1'b1;
          to_d[idx_q]   = 1'b1;
          acc_d         = 1'b0;
          state_d       = ST_NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      // Engine compare is registered: the last fault lands here.
      ST_CAPT: begin
        fail_d[idx_q] = acc_q | eng_fault;
        acc_d         = 1'b0;
        state_d       = ST_NEXT;
      end
      ST_NEXT: begin
        if (nxt_none) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = nxt_idx;
          state_d = ST_ERST;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      fail_q  <= '0;
      to_q    <= '0;
      acc_q   <= 1'b0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      fail_q  <= fail_d;
      to_q    <= to_d;
      acc_q   <= acc_d;
      mode_q  <= (state_d == ST_RUN) || (state_d == ST_CAPT);
      busy_q  <= (state_d == ST_ERST) || (state_d == ST_RUN) ||
                 (state_d == ST_CAPT) || (state_d == ST_NEXT);
      done_q  <= (state_d == ST_DONE);
    end
  end

`ifdef MBIST_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_map = to_q;
`else
  assign timeout_map = '0;
`endif

  assign eng_rst  = rst | (state_q == ST_ERST);
  assign eng_mode = mode_q;
  assign eng_sel  = idx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign fail_map = fail_q;

endmodule

// File: tb/tb_mbist_sched.sv
// Randomized bench for mbist_sched with a behavioural engine and
// a pass-level reference model.
module tb_mbist_sched;

  localparam int NM  = 4;
  localparam int TOC = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NM-1:0] mem_mask = '0;
  logic          eng_done = 1'b0;
  logic          eng_fault = 1'b0;
  logic          eng_rst, eng_mode, busy, done;
  logic [1:0]    eng_sel;
  logic [NM-1:0] fail_map, timeout_map;

  mbist_sched #(
    .NUM_MEM   (NM),
    .SEL_W     (2),
    .TO_CYCLES (TOC),
    .TO_W      (7)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mem_mask    (mem_mask),
    .eng_done    (eng_done),
    .eng_fault   (eng_fault),
    .eng_rst     (eng_rst),
    .eng_mode    (eng_mode),
    .eng_sel     (eng_sel),
    .busy        (busy),
    .done        (done),
    .fail_map    (fail_map),
    .timeout_map (timeout_map)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Engine stimulus: done L cycles after mode rises, fault at offset off.
  int L[NM];
  int off[NM];
  bit hang[NM];
  int mc = 0;

  always @(negedge clk) begin
    int nm;
    nm = eng_rst ? 0 : (eng_mode ? mc + 1 : mc);
    mc <= nm;
    eng_done  <= !hang[eng_sel] && (nm > L[eng_sel]);
    eng_fault <= eng_mode && (nm - 1 == off[eng_sel]);
  end

  int vq[$];
  int rst_cyc = 0, mode_cyc = 0, glitch = 0, bad_erst = 0;
  logic prev_mode = 1'b0;
  logic [1:0] prev_sel = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (eng_rst) begin
        vq.push_back(int'(eng_sel));
        rst_cyc <= rst_cyc + 1;
        if (!busy || eng_mode) bad_erst <= bad_erst + 1;
      end
      if (eng_mode) mode_cyc <= mode_cyc + 1;
      if (eng_mode && prev_mode && eng_sel != prev_sel)
        glitch <= glitch + 1;
    end
    prev_mode <= eng_mode;
    prev_sel  <= eng_sel;
  end

  int exp_lat, exp_mode;
  logic [NM-1:0] exp_fail, exp_to;
  int exp_vq[$];

  task automatic model(input logic [NM-1:0] m);
    bit timed;
    exp_lat  = 1;
    exp_mode = 0;
    exp_fail = '0;
    exp_to   = '0;
    exp_vq.delete();
    for (int i = 0; i < NM; i++) begin
      if (m[i]) begin
        exp_vq.push_back(i);
`ifdef MBIST_TIMEOUT_EN
        timed = hang[i] || (L[i] >= TOC);
`else
        timed = 1'b0;
`endif
        if (timed) begin
          exp_lat  += TOC + 2;
          exp_mode += TOC;
          exp_fail[i] = 1'b1;
          exp_to[i]   = 1'b1;
        end else begin
          exp_lat  += L[i] + 4;
          exp_mode += L[i] + 2;
          if (off[i] >= 0 && off[i] <= L[i] + 1) exp_fail[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input logic [NM-1:0] m);
    int k, b_v, b_r, b_m, b_g, b_b, gc, ec;
    model(m);
    b_v = vq.size();
    b_r = rst_cyc;
    b_m = mode_cyc;
    b_g = glitch;
    b_b = bad_erst;
    start    = 1'b1;
    mem_mask = m;
    tick();
    start    = 1'b0;
    mem_mask = NM'($urandom);
    k = 1;
    while (done !== 1'b1 && k < exp_lat + 50) begin
      tick();
      k++;
    end
    check("latency", k, exp_lat);
    check("done", done, 1);
    check("busy_end", busy, 0);
    check("mode_end", eng_mode, 0);
    check("fail_map", fail_map, exp_fail);
    check("timeout_map", timeout_map, exp_to);
    check("visit_cnt", vq.size() - b_v, exp_vq.size());
    gc = 0;
    ec = 0;
    for (int j = b_v; j < vq.size(); j++) gc = gc * 8 + vq[j] + 1;
    foreach (exp_vq[j]) ec = ec * 8 + exp_vq[j] + 1;
    check("visit_seq", gc, ec);
    check("erst_cycles", rst_cyc - b_r, exp_vq.size());
    check("mode_cycles", mode_cyc - b_m, exp_mode);
    check("sel_stable", glitch - b_g, 0);
    check("erst_outs", bad_erst - b_b, 0);
    repeat (3) tick();
    check("done_hold", done, 1);
    check("fail_hold", fail_map, exp_fail);
  endtask

  task automatic set_eng(input int len);
    for (int i = 0; i < NM; i++) begin
      L[i]    = len;
      off[i]  = -1;
      hang[i] = 1'b0;
    end
  endtask

  initial begin
    int w;
    set_eng(10);
    repeat (3) tick();
    check("rst_eng_rst", eng_rst, 1);
    check("rst_mode", eng_mode, 0);
    check("rst_sel", eng_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail_map, 0);
    check("rst_to", timeout_map, 0);
    rst = 1'b0;
    tick();
    check("idle_eng_rst", eng_rst, 0);

    set_eng(10);
    run_pass(4'b1111);

    set_eng(0);
    for (int i = 0; i < NM; i++) L[i] = $urandom_range(1, 12);
    off[3] = L[3] + 1;
    off[1] = L[1] + 2;
    run_pass(4'b1010);

    run_pass(4'b0000);

    set_eng(8);
    off[0] = 2;
    start    = 1'b1;
    mem_mask = 4'b0111;
    w = 0;
    while (!(eng_mode === 1'b1 && eng_sel === 2'd2) && w < 200) begin
      tick();
      w++;
    end
    check("reach_run2", w < 200, 1);
    check("pre_rst_fail", fail_map, 4'b0001);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_eng_rst", eng_rst, 1);
    tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_fail", fail_map, 0);
    check("post_rst_done", done, 0);
    check("post_rst_mode", eng_mode, 0);
    rst = 1'b0;
    off[0] = -1;
    run_pass(4'b0111);

`ifdef MBIST_TIMEOUT_EN
    set_eng(5);
    hang[0] = 1'b1;
    run_pass(4'b0011);
    set_eng(TOC - 1);
    L[1] = TOC;
    run_pass(4'b0011);
`endif

    set_eng(3);
    for (int i = 0; i < NM; i++) off[i] = i;
    run_pass(4'b1111);
    set_eng(6);
    run_pass(4'b0100);

    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < NM; i++) begin
        L[i]   = $urandom_range(0, 20);
        off[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(0, L[i] + 3) : -1;
`ifdef MBIST_TIMEOUT_EN
        hang[i] = ($urandom_range(0, 7) == 0);
`else
        hang[i] = 1'b0;
`endif
      end
      run_pass(NM'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
